dqpsk_diff_decoder: RTL and testbench
=====================================

# dqpsk_diff_decoder

Receive-side DQPSK symbol decoder. It sits after the I/Q matched FIR filters of the Costas loop and inverts the transmitter's differential encoder. It decimates filtered I/Q to one sample per symbol, slices each sample to a quadrant, and differences consecutive quadrants to recover the transmitted dibit. Recovered dibits leave on a valid/ready stream toward the parallel-to-serial stage.

## Interface
- IQ_W, 35: signed width of filtered I/Q samples.
- SPS, 100: input samples per symbol (10 MHz DDS clock / 100 kbaud).
- SAMPLE_OFFSET, 50: sample index within the symbol at which the slicer strobes; range 0..SPS-1.

- clk  in  1  sample clock (DDS clock domain)
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_i/in_q carry a valid filtered sample
- in_i  in  IQ_W  signed in-phase FIR output
- in_q  in  IQ_W  signed quadrature FIR output
- sym_sync  in  1  single-cycle pulse that realigns the symbol counter
- out_data  out  2  recovered dibit
- out_valid  out  1  out_data holds an untransferred dibit
- out_ready  in  1  downstream accepts out_data
- overrun  out  1  sticky flag: a dibit was dropped under backpressure

## Operation
- Sample counter `cnt` (0..SPS-1):
  - Advances only on in_valid and wraps SPS-1 -> 0.
  - Strobe = in_valid && cnt == SAMPLE_OFFSET.
- sym_sync:
  - With in_valid in the same cycle: the current sample is index 0, and cnt becomes 1.
  - Without in_valid: cnt becomes 0.
  - The strobe is evaluated with the post-sync index. If SAMPLE_OFFSET is 0, a sync sample strobes.
- Slicer: quadrant q from sign bits; zero counts as non-negative.
  - I≥0, Q≥0 -> 0
  - I<0, Q≥0 -> 1
  - I<0, Q<0 -> 2
  - I≥0, Q<0 -> 3
- Differential: delta = (q_cur − q_prev) mod 4 (2-bit wrap). q_prev <= q_cur on every strobe, including strobes whose dibit is dropped.
- Dibit map:
  - delta 0 -> 00
  - delta 1 -> 01
  - delta 2 and 3: see Configuration.
- FSM:
  - IDLE: after reset. The first strobe latches q_prev, no dibit is produced, and the FSM goes to REF.
  - REF: one-cycle pipeline fill state, then TRACK.
  - TRACK: every strobe produces a dibit.
  - sym_sync does not change state.
- Output register (single entry):
  - Loaded in stage 2 when out_valid==0, or when out_valid && out_ready in the same cycle. The old dibit transfers and the new one loads; overrun is not set.
  - If out_valid && !out_ready at load time: the new dibit is discarded, out_data is held, and overrun <= 1.
  - out_valid clears on a transfer with no simultaneous load.
- overrun clears only on reset.

## Timing
- Stage 1: register q_cur on the strobe cycle.
- Stage 2: compute delta and load the output register.
- Latency: out_valid rises on the 2nd clk edge after the edge that samples the strobing in_valid.
- Throughput: one dibit per SPS valid samples. SPS ≥ 3 is required.
- out_data is stable while out_valid && !out_ready.
- Reset values, applied immediately and asynchronously:
  - out_data=00, out_valid=0, overrun=0
  - cnt=0, q_prev=0, FSM=IDLE
  - pipeline stage empty
- Reset mid-operation discards any pending dibit. The first strobe after release becomes the new reference.

## Configuration
- DQPSK_GRAY_EN
  - Defined: Gray map, delta 2 -> 11, delta 3 -> 10.
  - Undefined: natural binary, delta 2 -> 10, delta 3 -> 11.
  - Must match the transmitter's build.

## Test plan
- Reset, then in_valid constant with I=Q=+1000 for 4 symbols:
  - No dibit for symbol 0.
  - Dibits 00, 00, 00 follow.
  - Each out_valid rises 2 clocks after the sample-50 edge.
- Quadrant sequence 0,1,3,3,2 with out_ready=1, DQPSK_GRAY_EN defined: out_data 01, 11, 00, 10.
- Build without DQPSK_GRAY_EN, sequence 0,2,1: out_data 10, 11.
- out_ready=0 across two strobes (quadrants 0 -> 1 -> 2):
  - The first dibit 01 is held.
  - The second is dropped and overrun=1.
  - After out_ready=1, the next strobe on quadrant 3 yields 01, proving q_prev advanced.
- sym_sync with in_valid at cnt=20: the next strobe occurs 50 valid samples later. in_valid gaps of 3 clocks delay the strobe by exactly 3 clocks.
- Assert rst for one cycle while out_valid=1 mid-symbol:
  - out_valid=0 and overrun=0 immediately.
  - The first post-reset strobe produces no dibit; the second produces one.

Source files
------------

// File: rtl/dqpsk_diff_decoder.sv
// DQPSK receive decoder: one strobe per symbol, quadrant slicer, differential decode.
// Define DQPSK_GRAY_EN for the Gray dibit map (must match the transmitter build).
module dqpsk_diff_decoder #(
    parameter int IQ_W          = 35,
    parameter int SPS           = 100,
    parameter int SAMPLE_OFFSET = 50
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [IQ_W-1:0] in_i,
    input  logic [IQ_W-1:0] in_q,
    input  logic            sym_sync,
    output logic [1:0]      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            overrun
);

    localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REF,
        TRACK
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, idx;
    logic             strobe;
    logic             i_neg, q_neg;
    logic [1:0]       q_slice, q_cur, q_prev, delta;
    logic             s1_valid, emit;
    logic             s2_valid;
    logic [1:0]       s2_dibit;

    function automatic logic [1:0] map_dibit(input logic [1:0] d);
`ifdef DQPSK_GRAY_EN
        return {d[1], d[1] ^ d[0]};
`else
        return d;
`endif
    endfunction

    // A sync pulse forces the current sample to index 0 before the strobe compare.
    // NOTE: give every always_comb output a default first so no path infers a latch.
    always_comb begin
        idx     = sym_sync ? '0 : cnt;
        cnt_nxt = sym_sync ? '0 : cnt;
        if (in_valid)
            cnt_nxt = (idx == CNT_W'(SPS - 1)) ? '0 : idx + 1'b1;
    end

    assign strobe = in_valid && (idx == CNT_W'(SAMPLE_OFFSET));

    // Quadrant index is {Q sign, I sign ^ Q sign}; zero counts as non-negative.
    assign i_neg   = $signed(in_i) < $signed(IQ_W'(0));
    assign q_neg   = $signed(in_q) < $signed(IQ_W'(0));
    assign q_slice = {q_neg, i_neg ^ q_neg};
    assign delta   = q_cur - q_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            q_cur    <= 2'd0;
        end else begin
            cnt      <= cnt_nxt;
            s1_valid <= strobe;
            if (strobe)
                q_cur <= q_slice;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s1_valid) state_nxt = REF;
            REF:     state_nxt = TRACK;
            TRACK:   state_nxt = TRACK;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        emit = 1'b0;
        if (state == TRACK)
            emit = s1_valid;
    end

    // Difference stage; the reference advances even when the dibit is later dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_prev   <= 2'd0;
            s2_valid <= 1'b0;
            s2_dibit <= 2'b00;
        end else begin
            s2_valid <= emit;
            if (s1_valid)
                q_prev <= q_cur;
            if (emit)
                s2_dibit <= map_dibit(delta);
        end
    end

    // Single-entry output register with drop-on-full and a sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= 2'b00;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (s2_valid) begin
            if (!out_valid || out_ready) begin
                out_data  <= s2_dibit;
                out_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dqpsk_diff_decoder.sv
// Self-checking bench for dqpsk_diff_decoder: symbol-level model plus directed literal checks.
`timescale 1ns/1ps
module tb_dqpsk_diff_decoder;

    localparam int IQ_W = 35;
    localparam int SPS  = 100;
    localparam int OFF  = 50;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   sym_sync = 1'b0;
    logic                   out_ready = 1'b1;
    logic signed [IQ_W-1:0] in_i = '0;
    logic signed [IQ_W-1:0] in_q = '0;
    logic [1:0]             out_data;
    logic                   out_valid;
    logic                   overrun;

    always #5 clk = ~clk;

    dqpsk_diff_decoder #(.IQ_W(IQ_W), .SPS(SPS), .SAMPLE_OFFSET(OFF)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_i     (in_i),
        .in_q     (in_q),
        .sym_sync (sym_sync),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun)
    );

    int     checks = 0;
    int     errors = 0;
    longint cycle  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [1:0] dibit_of(input int d);
        logic [1:0] r;
`ifdef DQPSK_GRAY_EN
        case (d)
            0:       r = 2'b00;
            1:       r = 2'b01;
            2:       r = 2'b11;
            default: r = 2'b10;
        endcase
`else
        r = 2'(d);
`endif
        return r;
    endfunction

    function automatic int quadrant(input logic signed [IQ_W-1:0] i, input logic signed [IQ_W-1:0] q);
        if (i >= 0 && q >= 0) return 0;
        if (i < 0 && q >= 0)  return 1;
        if (i < 0 && q < 0)   return 2;
        return 3;
    endfunction

    // Behavioural model: sample index, reference quadrant, 2-edge latency, one-entry output.
    int         m_idx = 0;
    int         m_prev = 0;
    bit         m_have_ref = 0;
    bit         p0_v = 0, p1_v = 0;
    logic [1:0] p0_d = 2'b00, p1_d = 2'b00;
    bit         m_v = 0;
    logic [1:0] m_d = 2'b00;
    bit         m_ovr = 0;

    initial forever begin
        bit         arr_v;
        logic [1:0] arr_d;
        int         index, qd;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_idx = 0; m_prev = 0; m_have_ref = 0;
            p0_v = 0; p1_v = 0; m_v = 0; m_d = 2'b00; m_ovr = 0;
        end else begin
            arr_v = p1_v; arr_d = p1_d;
            p1_v = p0_v;  p1_d = p0_d;
            p0_v = 0;
            if (arr_v) begin
                if (!m_v || out_ready) begin
                    m_v = 1; m_d = arr_d;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_v && out_ready) begin
                m_v = 0;
            end
            if (in_valid) begin
                index = sym_sync ? 0 : m_idx;
                m_idx = (index + 1) % SPS;
                if (index == OFF) begin
                    qd = quadrant(in_i, in_q);
                    if (m_have_ref) begin
                        p0_v = 1;
                        p0_d = dibit_of((qd - m_prev) & 3);
                    end
                    m_have_ref = 1;
                    m_prev     = qd;
                end
            end else if (sym_sync) begin
                m_idx = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("out_valid", out_valid, m_v);
        check("out_data", out_data, m_d);
        check("overrun", overrun, m_ovr);
    end

    // Monitor: record every dibit newly presented on the output and the edge it appeared on.
    logic [1:0] got_d[$];
    longint     got_c[$];
    longint     strobe_c[$];
    logic [1:0] exp_q[$];
    bit         last_v = 0, last_rdy = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            last_v = 0;
        end else begin
            if (out_valid === 1'b1 && (!last_v || last_rdy)) begin
                got_d.push_back(out_data);
                got_c.push_back(cycle);
            end
            last_v   = (out_valid === 1'b1);
            last_rdy = out_ready;
        end
    end

    task automatic drive(input bit v, input int qd, input longint mag, input bit sync);
        @(posedge clk); #1;
        in_valid = v;
        sym_sync = sync;
        in_i = (qd == 0 || qd == 3) ? IQ_W'(mag) : IQ_W'(-mag - 1);
        in_q = (qd <= 1)            ? IQ_W'(mag) : IQ_W'(-mag - 1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0);
    endtask

    task automatic run_symbol(input int qd, input longint mag);
        for (int j = 0; j < SPS; j++) begin
            drive(1, qd, mag, 0);
            if (j == OFF) strobe_c.push_back(cycle + 1);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; in_valid = 0; sym_sync = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        got_d.delete(); got_c.delete(); strobe_c.delete();
    endtask

    task automatic check_got(input string name);
        check({name, "_count"}, got_d.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got_d.size()) check($sformatf("%s_%0d", name, i), got_d[i], exp_q[i]);
    endtask

    initial begin
        longint sync_cyc;
        longint big = (64'sd1 <<< 34) - 1;

        #1 rst = 1;
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_overrun", overrun, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Constant quadrant 0: reference symbol, then three 00 dibits at 2-edge latency.
        run_symbol(0, 1000); run_symbol(0, 1000); run_symbol(0, 1000); run_symbol(0, 1000);
        idle(3);
        exp_q = {2'b00, 2'b00, 2'b00};
        check_got("t1_dibits");
        for (int k = 0; k < got_c.size() && k + 1 < strobe_c.size(); k++)
            check($sformatf("t1_latency_%0d", k), got_c[k] - strobe_c[k + 1], 2);

        // Quadrants 0,1,3,3,2 at full-scale amplitude.
        do_reset();
        run_symbol(0, big); run_symbol(1, big); run_symbol(3, big);
        run_symbol(3, big); run_symbol(2, big);
        idle(3);
`ifdef DQPSK_GRAY_EN
        exp_q = {2'b01, 2'b11, 2'b00, 2'b10};
`else
        exp_q = {2'b01, 2'b10, 2'b00, 2'b11};
`endif
        check_got("t2_dibits");

        // Quadrants 0,2,1 with samples at the zero / minus-one sign boundary.
        do_reset();
        run_symbol(0, 0); run_symbol(2, 0); run_symbol(1, 0);
        idle(3);
`ifdef DQPSK_GRAY_EN
        exp_q = {2'b11, 2'b10};
`else
        exp_q = {2'b10, 2'b11};
`endif
        check_got("t3_dibits");

        // Backpressure: 01 held, next dibit dropped, reference still advances.
        do_reset();
        out_ready = 0;
        run_symbol(0, 1000); run_symbol(1, 1000); run_symbol(2, 1000);
        @(negedge clk);
        check("t4_held_valid", out_valid, 1);
        check("t4_held_data", out_data, 2'b01);
        check("t4_overrun", overrun, 1);
        #1 out_ready = 1;
        run_symbol(3, 1000);
        exp_q = {2'b01, 2'b01};
        check_got("t4_dibits");

        // sym_sync with in_valid at cnt=20, then a 3-clock gap before the strobe.
        got_d.delete(); got_c.delete();
        for (int k = 0; k < 20; k++) drive(1, 1, 1000, 0);
        drive(1, 1, 1000, 1);
        sync_cyc = cycle + 1;
        for (int k = 1; k <= OFF; k++) begin
            if (k == 11) idle(3);
            drive(1, 1, 1000, 0);
        end
        idle(5);
`ifdef DQPSK_GRAY_EN
        exp_q = {2'b11};
`else
        exp_q = {2'b10};
`endif
        check_got("t5_dibits");
        if (got_c.size() > 0) check("t5_sync_latency", got_c[0] - sync_cyc, 55);

        // Asynchronous reset while a dibit is pending and overrun is set.
        got_d.delete(); got_c.delete();
        out_ready = 0;
        for (int k = 0; k < SPS; k++) drive(1, 2, 1000, 0);
        idle(3);
        @(negedge clk);
        check("t6_pre_valid", out_valid, 1);
        check("t6_pre_overrun", overrun, 1);
        @(posedge clk); #3;
        rst = 1;
        #1;
        check("t6_async_valid", out_valid, 0);
        check("t6_async_overrun", overrun, 0);
        check("t6_async_data", out_data, 0);
        @(posedge clk); #1;
        rst = 0;
        out_ready = 1;
        got_d.delete(); got_c.delete();
        run_symbol(0, 1000); run_symbol(1, 1000);
        idle(5);
        exp_q = {2'b01};
        check_got("t6_dibits");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
